// File: rtl/huffman_decode_ctrl.sv
// huffman_decode_ctrl
// Sequencing controller for the Huffman decode datapath. Appends 1-4 bit
// input chunks into an external bit shift register, watches an external
// combinational code-table decoder, hands each matched symbol downstream
// over valid/ready, then drops the matched bits from the shift register.
// Flags end-of-stream (done) and errors (overflow, trailing bits, bad length).
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   start                        begin a new stream from IDLE/DONE/ERR
//   in_valid/in_ready            input chunk handshake
//   in_bits/in_len/in_last       chunk bits (LSB newest), length 0..4, final flag
//   sr_load_bits/sr_in_bits/
//   sr_in_len                    shift register append command
//   sr_shift_en/sr_shift_len     shift register drop command
//   sr_bit_count                 shift register valid-bit count (registered)
//   dec_hit/dec_sym/dec_len      external decoder result
//   sym_valid/sym_ready/sym_data output symbol handshake
//   busy, done, err, err_code    status (err_code 1=overflow 2=trailing 3=bad length)
//   sym_count                    symbols delivered (only with SYM_COUNT_EN)
//
// Build option: define SYM_COUNT_EN to add the sym_count output and counter.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LOOKUP | evaluate decoder result, or accept a chunk, or finish
// EMIT   | present latched symbol until downstream accepts it
// WAIT   | settle cycle while shift register count/buffer update
// DONE   | stream fully decoded, waiting for start
// ERR    | error latched, waiting for start

module huffman_decode_ctrl #(
  parameter int MAX_CODE = 9,
  parameter int SYM_W    = 8
`ifdef SYM_COUNT_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_bits,
  input  logic [2:0]       in_len,
  input  logic             in_last,
  output logic             sr_load_bits,
  output logic [3:0]       sr_in_bits,
  output logic [2:0]       sr_in_len,
  output logic             sr_shift_en,
  output logic [3:0]       sr_shift_len,
  input  logic [3:0]       sr_bit_count,
  input  logic             dec_hit,
  input  logic [SYM_W-1:0] dec_sym,
  input  logic [3:0]       dec_len,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [SYM_W-1:0] sym_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
`ifdef SYM_COUNT_EN
  , output logic [CNT_W-1:0] sym_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EMIT, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [4:0] MaxCode5 = MAX_CODE[4:0];

  state_t           state_q, state_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [3:0]       len_q, len_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             start_acc;
  logic             hit_ok;
  logic             room_ok;
  logic             full;

  // A hit is only usable when its length is nonzero and fully buffered.
  assign hit_ok  = dec_hit && (dec_len != 4'd0) && (dec_len <= sr_bit_count);
  // 5-bit sum so a 4-bit count plus a 3-bit length cannot wrap.
  assign room_ok = (({1'b0, sr_bit_count} + {2'b00, in_len}) <= MaxCode5);
  assign full    = ({1'b0, sr_bit_count} >= MaxCode5);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sym_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sym_d        = sym_q;
    len_d        = len_q;
    last_d       = last_q;
    done_d       = done_q;
    err_d        = err_q;
    code_d       = code_q;
    start_acc    = 1'b0;
    in_ready     = 1'b0;
    sr_load_bits = 1'b0;
    sr_in_bits   = 4'd0;
    sr_in_len    = 3'd0;
    sr_shift_en  = 1'b0;
    sr_shift_len = 4'd0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          start_acc = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          code_d    = 2'd0;
          last_d    = 1'b0;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_ok) begin
          sym_d   = dec_sym;
          len_d   = dec_len;
          state_d = S_EMIT;
        end else if (dec_hit) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = S_ERR;
        end else if (full) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = S_ERR;
        end else if (!last_q) begin
          if (in_valid) begin
            if (in_len > 3'd4) begin
              err_d   = 1'b1;
              code_d  = 2'd3;
              state_d = S_ERR;
            end else if (in_len == 3'd0) begin
              in_ready = 1'b1;
              last_d   = in_last;
            end else if (room_ok) begin
              in_ready     = 1'b1;
              sr_load_bits = 1'b1;
              sr_in_bits   = in_bits;
              sr_in_len    = in_len;
              last_d       = in_last;
              state_d      = S_WAIT;
            end
          end
        end else if (sr_bit_count == 4'd0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_ERR;
        end
      end
      S_EMIT: begin
        if (sym_ready) begin
          sr_shift_en  = 1'b1;
          sr_shift_len = len_q;
          state_d      = S_WAIT;
        end
      end
      S_WAIT:  state_d = S_LOOKUP;
      default: state_d = S_IDLE;
    endcase
  end

  assign sym_valid = (state_q == S_EMIT);
  assign sym_data  = sym_q;
  assign busy      = (state_q == S_LOOKUP) || (state_q == S_EMIT) || (state_q == S_WAIT);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;

`ifdef SYM_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    cnt_q <= '0;
    else if (start_acc)              cnt_q <= '0;
    else if (sym_valid && sym_ready) cnt_q <= cnt_q + 1'b1;
  end
  assign sym_count = cnt_q;
`endif

endmodule

// File: tb/tb_huffman_decode_ctrl.sv
module tb_huffman_decode_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_bits;
  logic [2:0] in_len;
  logic       in_last;
  logic       sr_load_bits;
  logic [3:0] sr_in_bits;
  logic [2:0] sr_in_len;
  logic       sr_shift_en;
  logic [3:0] sr_shift_len;
  logic [3:0] sr_bit_count;
  logic       dec_hit;
  logic [7:0] dec_sym;
  logic [3:0] dec_len;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] sym_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
`ifdef SYM_COUNT_EN
  logic [15:0] sym_count;
`endif

  int checks = 0;
  int errors = 0;

  huffman_decode_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .in_len(in_len), .in_last(in_last),
    .sr_load_bits(sr_load_bits), .sr_in_bits(sr_in_bits), .sr_in_len(sr_in_len),
    .sr_shift_en(sr_shift_en), .sr_shift_len(sr_shift_len), .sr_bit_count(sr_bit_count),
    .dec_hit(dec_hit), .dec_sym(dec_sym), .dec_len(dec_len),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
`ifdef SYM_COUNT_EN
    , .sym_count(sym_count)
`endif
  );

  always #5 clk = ~clk;

  // Shift register model: oldest bit at position cnt-1, newest at bit 0.
  logic [8:0] sr_buf;
  logic [3:0] sr_cnt;
  logic       sr_clr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || sr_clr) begin
      sr_buf <= '0;
      sr_cnt <= '0;
    end else if (sr_load_bits) begin
      sr_buf <= (sr_buf << sr_in_len) | {5'd0, sr_in_bits & 4'((5'd1 << sr_in_len) - 5'd1)};
      sr_cnt <= sr_cnt + {1'b0, sr_in_len};
    end else if (sr_shift_en) begin
      sr_cnt <= sr_cnt - sr_shift_len;
    end
  end
  assign sr_bit_count = sr_cnt;

  // Decoder model: A=0, B=10, C=110. Mode 1 never hits, mode 2 bogus hit.
  int   dec_mode;
  logic b0, b1, b2;
  always_comb begin
    int c;
    c = int'(sr_cnt);
    b0 = (c >= 1) ? sr_buf[c-1] : 1'b0;
    b1 = (c >= 2) ? sr_buf[c-2] : 1'b0;
    b2 = (c >= 3) ? sr_buf[c-3] : 1'b0;
    dec_hit = 1'b0;
    dec_len = 4'd0;
    dec_sym = 8'h00;
    if (dec_mode == 0) begin
      if (c >= 1 && !b0) begin
        dec_hit = 1'b1; dec_len = 4'd1; dec_sym = 8'h41;
      end else if (c >= 2 && b0 && !b1) begin
        dec_hit = 1'b1; dec_len = 4'd2; dec_sym = 8'h42;
      end else if (c >= 3 && b0 && b1 && !b2) begin
        dec_hit = 1'b1; dec_len = 4'd3; dec_sym = 8'h43;
      end
    end else if (dec_mode == 2) begin
      dec_hit = 1'b1; dec_len = 4'd5; dec_sym = 8'hEE;
    end
  end

  logic [7:0] got_sym[$];
  int         got_len[$];
  always @(posedge clk) begin
    if (reset_n && sym_valid && sym_ready) got_sym.push_back(sym_data);
    if (reset_n && sr_shift_en) got_len.push_back(int'(sr_shift_len));
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      assert (!(sr_load_bits && sr_shift_en)) else begin
        errors++;
        $error("FAIL load_shift_overlap observed=1 expected=0");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_sr();
    sr_clr = 1'b1;
    @(negedge clk);
    sr_clr = 1'b0;
  endtask

  task automatic send(input logic [3:0] b, input logic [2:0] l, input logic last);
    int n;
    n = 0;
    in_bits = b; in_len = l; in_last = last; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    check("load_pulse", {31'd0, sr_load_bits}, 32'd1);
    check("load_bits", {28'd0, sr_in_bits}, {28'd0, b});
    check("load_len", {29'd0, sr_in_len}, {29'd0, l});
    @(negedge clk);
    in_valid = 1'b0; in_bits = 4'd0; in_len = 3'd0; in_last = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done || err) && k < 100) begin
      @(negedge clk); k++;
    end
    check("end_reached", {31'd0, done || err}, 32'd1);
  endtask

  task automatic wait_sym_valid();
    int k;
    k = 0;
    while (!sym_valid && k < 30) begin
      @(negedge clk); k++;
    end
    check("sym_valid_reached", {31'd0, sym_valid}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_bits = 4'd0; in_len = 3'd0;
    in_last = 1'b0; sym_ready = 1'b1; sr_clr = 1'b0; dec_mode = 0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
    check("rst_sym_data", {24'd0, sym_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Stream 101 | 100 -> B(2) C(3) A(1), then done.
    pulse_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    send(4'b0101, 3'd3, 1'b0);
    send(4'b0100, 3'd3, 1'b1);
    wait_end();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_bitcount", {28'd0, sr_bit_count}, 32'd0);
    check("t1_nsym", got_sym.size(), 32'd3);
    check("t1_nshift", got_len.size(), 32'd3);
    if (got_sym.size() == 3 && got_len.size() == 3) begin
      check("t1_sym0", {24'd0, got_sym[0]}, 32'h42);
      check("t1_sym1", {24'd0, got_sym[1]}, 32'h43);
      check("t1_sym2", {24'd0, got_sym[2]}, 32'h41);
      check("t1_len0", got_len[0], 32'd2);
      check("t1_len1", got_len[1], 32'd3);
      check("t1_len2", got_len[2], 32'd1);
    end
`ifdef SYM_COUNT_EN
    check("t1_sym_count", {16'd0, sym_count}, 32'd3);
`endif

    // Backpressure: symbol held for 5 cycles, then exactly one drop.
    got_sym.delete(); got_len.delete();
    sym_ready = 1'b0;
    pulse_start();
    check("t2_done_cleared", {31'd0, done}, 32'd0);
`ifdef SYM_COUNT_EN
    check("t2_sym_count_clr", {16'd0, sym_count}, 32'd0);
`endif
    send(4'b0000, 3'd1, 1'b1);
    wait_sym_valid();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", {31'd0, sym_valid}, 32'd1);
      check("t2_hold_data", {24'd0, sym_data}, 32'h41);
      check("t2_no_shift", {31'd0, sr_shift_en}, 32'd0);
      @(negedge clk);
    end
    sym_ready = 1'b1;
    #1;
    check("t2_shift_en", {31'd0, sr_shift_en}, 32'd1);
    check("t2_shift_len", {28'd0, sr_shift_len}, 32'd1);
    @(negedge clk);
    check("t2_valid_drop", {31'd0, sym_valid}, 32'd0);
    wait_end();
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_nshift", got_len.size(), 32'd1);

    // Overflow: decoder never hits, 4+4 bits then a stalled 2-bit chunk.
    clear_sr();
    dec_mode = 1;
    pulse_start();
    send(4'hF, 3'd4, 1'b0);
    send(4'hF, 3'd4, 1'b0);
    in_valid = 1'b1; in_bits = 4'h3; in_len = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_stall", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    check("t3_count8", {28'd0, sr_bit_count}, 32'd8);
    send(4'h1, 3'd1, 1'b0);
    wait_end();
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_err_code", {30'd0, err_code}, 32'd1);
    check("t3_count9", {28'd0, sr_bit_count}, 32'd9);
    check("t3_done", {31'd0, done}, 32'd0);

    // Trailing bits: "11" with last never matches.
    clear_sr();
    dec_mode = 0;
    pulse_start();
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    send(4'b0011, 3'd2, 1'b1);
    wait_end();
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_err_code", {30'd0, err_code}, 32'd2);

    // Malformed chunk length.
    clear_sr();
    pulse_start();
    in_valid = 1'b1; in_bits = 4'hF; in_len = 3'd6;
    #1;
    check("t5_no_ready", {31'd0, in_ready}, 32'd0);
    check("t5_no_load", {31'd0, sr_load_bits}, 32'd0);
    @(negedge clk);
    check("t5_no_ready2", {31'd0, in_ready}, 32'd0);
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_err_code", {30'd0, err_code}, 32'd3);
    in_valid = 1'b0; in_len = 3'd0; in_bits = 4'd0;

    // Decoder hit longer than the buffer.
    clear_sr();
    dec_mode = 2;
    pulse_start();
    @(negedge clk);
    check("t5b_err", {31'd0, err}, 32'd1);
    check("t5b_err_code", {30'd0, err_code}, 32'd3);
    dec_mode = 0;

    // Reset while in EMIT, then a fresh stream.
    clear_sr();
    sym_ready = 1'b0;
    pulse_start();
    send(4'b0000, 3'd1, 1'b1);
    wait_sym_valid();
    reset_n = 1'b0;
    #1;
    check("t6_sym_valid", {31'd0, sym_valid}, 32'd0);
    check("t6_sym_data", {24'd0, sym_data}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_shift", {31'd0, sr_shift_en}, 32'd0);
    check("t6_load", {31'd0, sr_load_bits}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    sym_ready = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    got_sym.delete(); got_len.delete();
    pulse_start();
    send(4'b0010, 3'd2, 1'b1);
    wait_end();
    check("t6_done_after", {31'd0, done}, 32'd1);
    check("t6_nsym", got_sym.size(), 32'd1);
    if (got_sym.size() == 1) check("t6_sym", {24'd0, got_sym[0]}, 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
